alu_bitserial_seq: RTL and testbench
====================================

Name: alu_bitserial_seq

Overview:
- Bit-serial sequencer that sits directly upstream of, and around, the 1-bit ALU slice.
- Latches two WIDTH-bit operands and a 6-bit funct code.
- Walks the slice one bit per clock, LSB first, and feeds the slice's carry-out back as the next carry-in.
- Collects the slice output bits into a result word, then applies SLT post-processing and a zero flag.
- Replaces a WIDTH-slice ripple array with one shared slice for area-limited builds.

Parameters:
WIDTH, 32, operand/result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
dataA  input  WIDTH  operand A, captured on accepted start
dataB  input  WIDTH  operand B, captured on accepted start
Signal  input  6  funct: 36 AND, 37 OR, 32 ADD, 34 SUB, 42 SLT
busy  output  1  high while operation in flight (RUN, FIN)
done  output  1  one-cycle pulse when dataOut/zero are valid
dataOut  output  WIDTH  result, held until next done
zero  output  1  dataOut == 0, registered with dataOut
slice_a  output  1  to slice a = A_reg[idx]
slice_b  output  1  to slice b = B_reg[idx]
slice_cin  output  1  to slice cin = carry_reg
slice_inv  output  1  to slice inv = inv_reg
slice_signal  output  6  to slice Signal = op_reg
slice_out  input  1  from slice out
slice_cout  input  1  from slice cout

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all registers 0; busy=0, done=0, dataOut=0, zero=0.
- Reset mid-operation aborts the operation; no done is produced.
- States:
  - IDLE: start=1 at edge E0 -> latch A_reg, B_reg, op_reg; idx=0; inv_reg=1 for SUB/SLT, else 0; carry_reg=inv_reg; go to RUN.
  - RUN: each edge -> res_reg[idx]<=slice_out, carry_reg<=slice_cout. At idx=WIDTH-1 also capture cin_msb<=carry_reg and A/B msb-sum bit; go to FIN; otherwise idx<=idx+1.
  - FIN: one edge -> update dataOut and zero, pulse done; return to IDLE.
- Latency: start accepted at E0; bits captured at E1..E_WIDTH; done high for the cycle after edge E_(WIDTH+1). busy is high over the same span.
- start while busy is ignored, with no queuing. start during the done cycle (IDLE) is accepted, giving back-to-back issue.
- Results:
  - AND/OR/ADD/SUB: dataOut = res_reg, ADD/SUB modulo 2^WIDTH; overflow not flagged.
  - SLT: less = sum_msb XOR (cin_msb XOR cout_msb); dataOut = {WIDTH-1 zeros, less}. The result is signed and correct under overflow.
  - Unknown funct: inv=0, slice yields the sum; dataOut = A+B, done as normal.
- Slice outputs outside RUN: slice_a=slice_b=slice_cin=0; slice_inv and slice_signal keep last latched values.
- Operand inputs may change freely after the accept edge.

Test Plan:
1. ADD, A=5, B=7, start one cycle -> done exactly WIDTH+1 edges after accept; dataOut=12, zero=0; busy high WIDTH+1 cycles.
2. SUB, A=3, B=5 -> dataOut=0xFFFFFFFE, zero=0; then SUB A=B=0x1234 -> dataOut=0, zero=1.
3. SLT, A=0xFFFFFFFF, B=1 -> dataOut=1; SLT A=0x7FFFFFFF, B=0x80000000 (overflow) -> dataOut=0.
4. AND/OR, A=0xF0F0F0F0, B=0xFF00FF00 -> AND 0xF000F000, OR 0xFFF0FFF0. Issue back-to-back, start asserted in the done cycle.
5. Assert start with new operands during RUN -> ignored; first result unchanged; exactly one done.
6. Pull rst_n low at idx=10 of an ADD -> outputs 0 immediately, no done. A following ADD 1+1 -> dataOut=2.

Source files
------------

// File: rtl/alu_bitserial_seq.sv
// Bit-serial ALU sequencer: drives one shared 1-bit ALU slice LSB-first,
// ripples the carry through a register, gathers the result word, then
// applies SLT post-processing and the zero flag.
module alu_bitserial_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dataOut,
  output logic             zero,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_inv,
  output logic [5:0]       slice_signal,
  input  logic             slice_out,
  input  logic             slice_cout
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
  localparam logic [5:0] F_SUB = 6'd34;
  localparam logic [5:0] F_SLT = 6'd42;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic [5:0]       op_reg;
  logic [IW-1:0]    idx;
  logic             inv_reg, carry_reg, cin_msb, sum_msb;
  logic             start_inv, less;
  logic [WIDTH-1:0] result_w;

  // SUB and SLT run the slice as a + ~b + 1
  assign start_inv = (Signal == F_SUB) || (Signal == F_SLT);

  // In FIN carry_reg holds the MSB carry-out, so overflow = cin_msb ^ carry_reg
  assign less     = sum_msb ^ (cin_msb ^ carry_reg);
  assign result_w = (op_reg == F_SLT) ? {{(WIDTH-1){1'b0}}, less} : res_reg;

  assign busy         = (state == RUN) || (state == FIN);
  assign slice_a      = (state == RUN) ? a_reg[idx] : 1'b0;
  assign slice_b      = (state == RUN) ? b_reg[idx] : 1'b0;
  assign slice_cin    = (state == RUN) ? carry_reg  : 1'b0;
  assign slice_inv    = inv_reg;
  assign slice_signal = op_reg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic: accept in IDLE, walk WIDTH bits, one finish cycle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (idx == IDX_LAST) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, bit walk, result publish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      op_reg    <= '0;
      idx       <= '0;
      inv_reg   <= 1'b0;
      carry_reg <= 1'b0;
      cin_msb   <= 1'b0;
      sum_msb   <= 1'b0;
      dataOut   <= '0;
      zero      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_reg     <= dataA;
          b_reg     <= dataB;
          op_reg    <= Signal;
          idx       <= '0;
          res_reg   <= '0;
          inv_reg   <= start_inv;
          carry_reg <= start_inv;
        end
        RUN: begin
          res_reg[idx] <= slice_out;
          carry_reg    <= slice_cout;
          if (idx == IDX_LAST) begin
            cin_msb <= carry_reg;
            // sign bit of a + (b ^ inv) + cin, independent of the slice's funct decode
            sum_msb <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ inv_reg ^ carry_reg;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        FIN: begin
          dataOut <= result_w;
          zero    <= (result_w == '0);
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bitserial_seq.sv
module tb_alu_bitserial_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dataA = '0, dataB = '0;
  logic [5:0]   Signal = '0;
  logic         busy, done, zero;
  logic [W-1:0] dataOut;
  logic         slice_a, slice_b, slice_cin, slice_inv;
  logic [5:0]   slice_signal;
  logic         slice_out, slice_cout;

  int n_cmp = 0;
  int n_bad = 0;

  alu_bitserial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dataA(dataA), .dataB(dataB),
    .Signal(Signal), .busy(busy), .done(done), .dataOut(dataOut), .zero(zero),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_inv(slice_inv), .slice_signal(slice_signal),
    .slice_out(slice_out), .slice_cout(slice_cout)
  );

  always #5 clk = ~clk;

  // 1-bit ALU slice model
  logic bb;
  always_comb begin
    bb         = slice_b ^ slice_inv;
    slice_cout = (slice_a & bb) | (slice_a & slice_cin) | (bb & slice_cin);
    case (slice_signal)
      6'd36:   slice_out = slice_a & slice_b;
      6'd37:   slice_out = slice_a | slice_b;
      default: slice_out = slice_a ^ bb ^ slice_cin;
    endcase
  end

  // Whole-word reference
  function automatic logic [W-1:0] ref_alu(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      6'd36:   return a & b;
      6'd37:   return a | b;
      6'd34:   return a - b;
      6'd42:   return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return a + b;
    endcase
  endfunction

  // Issue one op (called at a negedge) and wait for done; returns at the done negedge
  task automatic run_op(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_cnt, output bit timeout);
    start = 1'b1; Signal = op; dataA = a; dataB = b;
    lat = 0; busy_cnt = 0; timeout = 1'b0;
    @(negedge clk);
    start = 1'b0; dataA = $urandom; dataB = $urandom; Signal = 6'($urandom);
    while (!done) begin
      if (busy) busy_cnt++;
      lat++;
      if (lat > 4 * W) begin timeout = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || dataOut !== '0 || zero !== 1'b0 ||
        slice_a !== 1'b0 || slice_cin !== 1'b0 || slice_signal !== 6'd0) begin
      n_bad++;
      $display("FAIL reset: busy=%b done=%b dataOut=%h zero=%b sa=%b scin=%b ssig=%0d want all 0",
               busy, done, dataOut, zero, slice_a, slice_cin, slice_signal);
    end
  endtask

  task automatic test_add_timing();
    int lat, bc; bit to;
    run_op(6'd32, 32'd5, 32'd7, lat, bc, to);
    n_cmp++;
    if (to || dataOut !== 32'd12 || zero !== 1'b0) begin
      n_bad++; $display("FAIL add5_7: dataOut=%h zero=%b to=%b want 0000000c/0", dataOut, zero, to);
    end
    n_cmp++;
    if (lat !== W + 1 || bc !== W + 1) begin
      n_bad++; $display("FAIL add_latency: lat=%0d busy=%0d want %0d/%0d", lat, bc, W + 1, W + 1);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || dataOut !== 32'd12) begin
      n_bad++; $display("FAIL done_pulse: done=%b busy=%b dataOut=%h want 0/0/0000000c", done, busy, dataOut);
    end
    n_cmp++;
    if (slice_a !== 1'b0 || slice_b !== 1'b0 || slice_cin !== 1'b0 || slice_signal !== 6'd32 || slice_inv !== 1'b0) begin
      n_bad++; $display("FAIL idle_slice: a=%b b=%b cin=%b sig=%0d inv=%b want 0/0/0/32/0",
                        slice_a, slice_b, slice_cin, slice_signal, slice_inv);
    end
  endtask

  task automatic test_sub_slt();
    int lat, bc; bit to;
    run_op(6'd34, 32'd3, 32'd5, lat, bc, to);
    n_cmp++;
    if (to || dataOut !== 32'hFFFF_FFFE || zero !== 1'b0) begin
      n_bad++; $display("FAIL sub3_5: dataOut=%h zero=%b want fffffffe/0", dataOut, zero);
    end
    run_op(6'd34, 32'h1234, 32'h1234, lat, bc, to);
    n_cmp++;
    if (to || dataOut !== '0 || zero !== 1'b1) begin
      n_bad++; $display("FAIL sub_eq: dataOut=%h zero=%b want 0/1", dataOut, zero);
    end
    n_cmp++;
    if (slice_inv !== 1'b1 || slice_signal !== 6'd34) begin
      n_bad++; $display("FAIL sub_inv_hold: inv=%b sig=%0d want 1/34", slice_inv, slice_signal);
    end
    run_op(6'd42, 32'hFFFF_FFFF, 32'd1, lat, bc, to);
    n_cmp++;
    if (to || dataOut !== 32'd1 || zero !== 1'b0) begin
      n_bad++; $display("FAIL slt_neg: dataOut=%h zero=%b want 1/0", dataOut, zero);
    end
    run_op(6'd42, 32'h7FFF_FFFF, 32'h8000_0000, lat, bc, to);
    n_cmp++;
    if (to || dataOut !== 32'd0 || zero !== 1'b1) begin
      n_bad++; $display("FAIL slt_ovf: dataOut=%h zero=%b want 0/1", dataOut, zero);
    end
    run_op(6'd42, 32'h8000_0000, 32'h7FFF_FFFF, lat, bc, to);
    n_cmp++;
    if (to || dataOut !== 32'd1) begin
      n_bad++; $display("FAIL slt_ovf2: dataOut=%h want 1", dataOut);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc; bit to;
    run_op(6'd36, 32'hF0F0_F0F0, 32'hFF00_FF00, lat, bc, to);
    n_cmp++;
    if (to || dataOut !== 32'hF000_F000) begin
      n_bad++; $display("FAIL and: dataOut=%h want f000f000", dataOut);
    end
    // issued in the done cycle
    run_op(6'd37, 32'hF0F0_F0F0, 32'hFF00_FF00, lat, bc, to);
    n_cmp++;
    if (to || dataOut !== 32'hFFF0_FFF0 || lat !== W + 1) begin
      n_bad++; $display("FAIL or_b2b: dataOut=%h lat=%0d want fff0fff0/%0d", dataOut, lat, W + 1);
    end
    run_op(6'd7, 32'hFFFF_FFFF, 32'd2, lat, bc, to);
    n_cmp++;
    if (to || dataOut !== 32'd1) begin
      n_bad++; $display("FAIL unknown_funct: dataOut=%h want 1", dataOut);
    end
  endtask

  task automatic test_start_ignored();
    int dones = 0;
    @(negedge clk);
    start = 1'b1; Signal = 6'd32; dataA = 32'd100; dataB = 32'd23;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3 * W; i++) begin
      if (i >= 5 && i < 9) begin start = 1'b1; Signal = 6'd34; dataA = 32'd9; dataB = 32'd4; end
      else start = 1'b0;
      if (done) dones++;
      if (done) begin
        n_cmp++;
        if (dataOut !== 32'd123) begin
          n_bad++; $display("FAIL start_ignored_result: dataOut=%h want 0000007b", dataOut);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_cmp++;
    if (dones !== 1) begin
      n_bad++; $display("FAIL start_ignored_count: dones=%0d want 1", dones);
    end
  endtask

  task automatic test_reset_midop();
    int dones = 0; int lat, bc; bit to;
    @(negedge clk);
    start = 1'b1; Signal = 6'd32; dataA = 32'h1111; dataB = 32'h2222;
    @(negedge clk);
    start = 1'b0;
    // after the accept edge plus 10 RUN edges idx is 10
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dataOut !== '0 || busy !== 1'b0 || done !== 1'b0 || zero !== 1'b0) begin
      n_bad++; $display("FAIL midop_reset: dataOut=%h busy=%b done=%b zero=%b want 0", dataOut, busy, done, zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 8; i++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++; $display("FAIL midop_no_done: activity=%0d want 0", dones);
    end
    run_op(6'd32, 32'd1, 32'd1, lat, bc, to);
    n_cmp++;
    if (to || dataOut !== 32'd2) begin
      n_bad++; $display("FAIL after_reset_add: dataOut=%h want 2", dataOut);
    end
  endtask

  task automatic test_random();
    int lat, bc; bit to;
    logic [5:0] ops [6] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd0};
    logic [5:0] op; logic [W-1:0] a, b, exp;
    for (int i = 0; i < 60; i++) begin
      op = ops[$urandom_range(0, 5)];
      if (op == 6'd0) op = 6'($urandom);
      a = $urandom; b = $urandom;
      if (i % 7 == 0) b = a;
      if (i % 11 == 0) a = 32'h8000_0000;
      exp = ref_alu(op, a, b);
      if ($urandom_range(0, 2) == 0) @(negedge clk);
      run_op(op, a, b, lat, bc, to);
      n_cmp++;
      if (to || dataOut !== exp || zero !== (exp == '0) || lat !== W + 1) begin
        n_bad++;
        $display("FAIL rand[%0d] op=%0d a=%h b=%h: dataOut=%h zero=%b lat=%0d want %h/%b/%0d",
                 i, op, a, b, dataOut, zero, lat, exp, (exp == '0), W + 1);
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_add_timing();
    @(negedge clk);
    test_sub_slt();
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_start_ignored();
    test_reset_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
